// File: rtl/triroc_sc_pkg.sv
// Shared defaults, chain-select encoding and counter sizing for the TRIROC
// slow-control / probe shift-register chains.
package triroc_sc_pkg;

    localparam int SC_WIDTH_DEFAULT    = 1256;
    localparam int PROBE_WIDTH_DEFAULT = 416;

    localparam logic SEL_SC    = 1'b1;
    localparam logic SEL_PROBE = 1'b0;

    // One spare bit above the longest chain length so an over-long shift is
    // still distinguishable from a correct one before saturation.
    function automatic int cnt_width(input int sc_w, input int probe_w);
        int longest;
        longest = (sc_w > probe_w) ? sc_w : probe_w;
        return $clog2(longest + 1) + 1;
    endfunction

endpackage

// File: rtl/triroc_sr_chain.sv
// One serial configuration chain: shift register plus the shadow copy that
// actually drives the front-end, and the MSB tap used for serial read-back.
module triroc_sr_chain #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ck_sr,
    input  logic             rstb_sr,
    input  logic             shift_en,
    input  logic             sr_in,
    input  logic             copy_en,
    output logic             msb,
    output logic [WIDTH-1:0] cfg
);

    logic [WIDTH-1:0] chain;

    // The shadow captures the pre-edge chain, so a shift on the copy edge
    // does not leak into the applied configuration.
    always_ff @(posedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            chain <= RESET_VAL;
            cfg   <= RESET_VAL;
        end else begin
            if (shift_en) begin
                chain <= {chain[WIDTH-2:0], sr_in};
            end
            if (copy_en) begin
                cfg <= chain;
            end
        end
    end

    assign msb = chain[WIDTH-1];

endmodule

// File: rtl/triroc_sc_chain_ctrl.sv
// Slow-control / probe chain controller: bit counting, load-edge detection,
// length check against the selected chain and negedge serial output.
module triroc_sc_chain_ctrl
    import triroc_sc_pkg::*;
#(
    parameter int                     SC_WIDTH    = SC_WIDTH_DEFAULT,
    parameter int                     PROBE_WIDTH = PROBE_WIDTH_DEFAULT,
    parameter logic [SC_WIDTH-1:0]    SC_RESET    = '0,
    parameter logic [PROBE_WIDTH-1:0] PROBE_RESET = '0,
    parameter int                     CNT_W       = cnt_width(SC_WIDTH, PROBE_WIDTH)
) (
    input  logic                   ck_sr,
    input  logic                   rstb_sr,
    input  logic                   sr_in,
    input  logic                   select,
    input  logic                   load_sc,
    output logic                   sr_out,
    output logic [SC_WIDTH-1:0]    sc_cfg,
    output logic [PROBE_WIDTH-1:0] probe_cfg,
    output logic [CNT_W-1:0]       bit_cnt,
    output logic                   load_done,
    output logic                   len_err
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SC_LEN    = CNT_W'(SC_WIDTH);
    localparam logic [CNT_W-1:0] PROBE_LEN = CNT_W'(PROBE_WIDTH);

    logic select_d;
    logic load_sc_d;
    logic load_evt;
    logic sel_chg;
    logic len_ok;
    logic sc_copy;
    logic probe_copy;
    logic sc_msb;
    logic probe_msb;

    // load_sc_d resets high so a load_sc held low through reset release
    // does not look like a falling edge.
    assign load_evt = !load_sc && load_sc_d;
    assign sel_chg  = (select != select_d);

    always_comb begin
        len_ok = 1'b0;
        if (select == SEL_SC) begin
            len_ok = (bit_cnt == SC_LEN);
        end else begin
            len_ok = (bit_cnt == PROBE_LEN);
        end
    end

    assign sc_copy    = load_evt && (select == SEL_SC)    && len_ok;
    assign probe_copy = load_evt && (select == SEL_PROBE) && len_ok;

    triroc_sr_chain #(
        .WIDTH     (SC_WIDTH),
        .RESET_VAL (SC_RESET)
    ) u_sc_chain (
        .ck_sr    (ck_sr),
        .rstb_sr  (rstb_sr),
        .shift_en (select == SEL_SC),
        .sr_in    (sr_in),
        .copy_en  (sc_copy),
        .msb      (sc_msb),
        .cfg      (sc_cfg)
    );

    triroc_sr_chain #(
        .WIDTH     (PROBE_WIDTH),
        .RESET_VAL (PROBE_RESET)
    ) u_probe_chain (
        .ck_sr    (ck_sr),
        .rstb_sr  (rstb_sr),
        .shift_en (select == SEL_PROBE),
        .sr_in    (sr_in),
        .copy_en  (probe_copy),
        .msb      (probe_msb),
        .cfg      (probe_cfg)
    );

    always_ff @(posedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            select_d  <= SEL_SC;
            load_sc_d <= 1'b1;
            bit_cnt   <= '0;
            load_done <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            select_d  <= select;
            load_sc_d <= load_sc;
            load_done <= sc_copy || probe_copy;
            if (load_evt) begin
                bit_cnt <= '0;
                len_err <= !len_ok;
            end else if (sel_chg) begin
                bit_cnt <= CNT_ONE;
            end else if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
        end
    end

    // Half-cycle retiming gives the downstream chip a full half period of
    // setup on its own posedge; select_d names the chain that just shifted.
    always_ff @(negedge ck_sr or negedge rstb_sr) begin
        if (!rstb_sr) begin
            sr_out <= SC_RESET[SC_WIDTH-1];
        end else begin
            sr_out <= (select_d == SEL_SC) ? sc_msb : probe_msb;
        end
    end

endmodule

// File: tb/tb_triroc_sc_chain_ctrl.sv
// Directed scoreboard bench for triroc_sc_chain_ctrl: stimulus queues the
// expected shadow contents of each accepted load, a monitor checks load_done.
module tb_triroc_sc_chain_ctrl;
    import triroc_sc_pkg::*;

    localparam int SCW = SC_WIDTH_DEFAULT;
    localparam int PRW = PROBE_WIDTH_DEFAULT;
    localparam int CW  = cnt_width(SCW, PRW);

    typedef logic [SCW-1:0] vec_t;
    typedef struct {
        vec_t           sc;
        logic [PRW-1:0] pr;
    } exp_t;

    logic           ck_sr   = 1'b0;
    logic           rstb_sr = 1'b0;
    logic           sr_in   = 1'b0;
    logic           select  = 1'b1;
    logic           load_sc = 1'b1;
    logic           sr_out;
    logic [SCW-1:0] sc_cfg;
    logic [PRW-1:0] probe_cfg;
    logic [CW-1:0]  bit_cnt;
    logic           load_done;
    logic           len_err;

    int             n_tests = 0;
    int             n_fail  = 0;
    exp_t           exp_q[$];
    exp_t           mon_e;
    vec_t           sc_exp  = '0;
    logic [PRW-1:0] pr_exp  = '0;
    vec_t           pat1, pat2, pat3, pat4, ppat;

    triroc_sc_chain_ctrl dut (
        .ck_sr     (ck_sr),
        .rstb_sr   (rstb_sr),
        .sr_in     (sr_in),
        .select    (select),
        .load_sc   (load_sc),
        .sr_out    (sr_out),
        .sc_cfg    (sc_cfg),
        .probe_cfg (probe_cfg),
        .bit_cnt   (bit_cnt),
        .load_done (load_done),
        .len_err   (len_err)
    );

    always #60 ck_sr = ~ck_sr;

    task automatic check(input string name, input vec_t act, input vec_t req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < SCW; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Inputs change just after a negedge; the DUT samples them on the
    // following posedge and the call returns on the next negedge.
    task automatic step(input logic d, input logic s, input logic l);
        sr_in   = d;
        select  = s;
        load_sc = l;
        @(negedge ck_sr);
    endtask

    // Shift pattern bits MSB-first, bit index (w-1-k) for k in [from, to).
    task automatic shift_bits(input vec_t p, input int w, input int from, input int to,
                              input logic s);
        for (int k = from; k < to; k++) step(p[w-1-k], s, 1'b1);
    endtask

    task automatic do_load(input logic s, input logic ok);
        exp_t e;
        if (ok) begin
            e.sc = sc_exp;
            e.pr = pr_exp;
            exp_q.push_back(e);
        end
        step(1'b0, s, 1'b0);
        check("load_done", SCW'(load_done), SCW'(ok));
        check("load_len_err", SCW'(len_err), SCW'(!ok));
        check("load_bit_cnt", SCW'(bit_cnt), '0);
        check("load_sc_cfg", sc_cfg, sc_exp);
        check("load_probe_cfg", SCW'(probe_cfg), SCW'(pr_exp));
    endtask

    // Every load_done must match one queued expectation, exactly once.
    always @(negedge ck_sr) begin
        if (rstb_sr && load_done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_load_done_unexpected: actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_sc_cfg", sc_cfg, mon_e.sc);
                check("mon_probe_cfg", SCW'(probe_cfg), SCW'(mon_e.pr));
                check("mon_len_err", SCW'(len_err), '0);
                check("mon_bit_cnt", SCW'(bit_cnt), '0);
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat1 = rand_vec();
        pat2 = rand_vec();
        pat3 = rand_vec();
        pat4 = rand_vec();
        ppat = rand_vec();
        ppat[PRW-1] = 1'b1;

        // Reset state
        repeat (3) @(negedge ck_sr);
        check("rst_sc_cfg", sc_cfg, '0);
        check("rst_probe_cfg", SCW'(probe_cfg), '0);
        check("rst_bit_cnt", SCW'(bit_cnt), '0);
        check("rst_load_done", SCW'(load_done), '0);
        check("rst_len_err", SCW'(len_err), '0);
        check("rst_sr_out", SCW'(sr_out), '0);
        #20 rstb_sr = 1'b1;

        // Good SC load; first post-reset edge is a plain shift
        step(pat1[SCW-1], 1'b1, 1'b1);
        check("first_edge_bit_cnt", SCW'(bit_cnt), SCW'(1));
        shift_bits(pat1, SCW, 1, SCW, 1'b1);
        check("full_bit_cnt", SCW'(bit_cnt), SCW'(SCW));
        check("shift_sc_cfg_stable", sc_cfg, '0);
        sc_exp = pat1;
        do_load(1'b1, 1'b1);

        // Short SC load rejected, then a correct one clears len_err
        shift_bits(pat2, SCW, 0, SCW - 1, 1'b1);
        do_load(1'b1, 1'b0);
        shift_bits(pat2, SCW, 0, SCW, 1'b1);
        check("len_err_sticky", SCW'(len_err), SCW'(1));
        sc_exp = pat2;
        do_load(1'b1, 1'b1);

        // Probe load; sr_out follows the probe MSB half a cycle late
        shift_bits(ppat, PRW, 0, PRW - 1, 1'b0);
        sr_in   = ppat[0];
        select  = 1'b0;
        load_sc = 1'b1;
        @(posedge ck_sr);
        #1 check("sr_out_before_negedge", SCW'(sr_out), '0);
        @(negedge ck_sr);
        #1 check("sr_out_after_negedge", SCW'(sr_out), SCW'(1));
        check("probe_bit_cnt", SCW'(bit_cnt), SCW'(PRW));
        pr_exp = ppat[PRW-1:0];
        do_load(1'b0, 1'b1);
        check("sc_chain_untouched", dut.u_sc_chain.chain, {pat2[SCW-2:0], 1'b0});

        // Asynchronous reset mid-cycle during a shift, with len_err set
        shift_bits(pat3, SCW, 0, 300, 1'b1);
        do_load(1'b1, 1'b0);
        shift_bits(pat3, SCW, 0, 600, 1'b1);
        #20 rstb_sr = 1'b0;
        #1;
        sc_exp = '0;
        pr_exp = '0;
        check("async_rst_bit_cnt", SCW'(bit_cnt), '0);
        check("async_rst_sc_cfg", sc_cfg, '0);
        check("async_rst_probe_cfg", SCW'(probe_cfg), '0);
        check("async_rst_len_err", SCW'(len_err), '0);
        check("async_rst_sr_out", SCW'(sr_out), '0);
        check("async_rst_sc_chain", dut.u_sc_chain.chain, '0);
        @(negedge ck_sr);
        #20 rstb_sr = 1'b1;
        shift_bits(pat3, SCW, 0, SCW, 1'b1);
        sc_exp = pat3;
        do_load(1'b1, 1'b1);

        // load_sc held low for five edges gives one event
        shift_bits(pat4, SCW, 0, SCW, 1'b1);
        sc_exp = pat4;
        do_load(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("held_low_bit_cnt", SCW'(bit_cnt), SCW'(4));
        check("held_low_len_err", SCW'(len_err), '0);

        // Select toggle restarts the count at 1
        shift_bits(pat1, SCW, 0, 10, 1'b1);
        check("pre_toggle_bit_cnt", SCW'(bit_cnt), SCW'(14));
        step(1'b1, 1'b0, 1'b1);
        check("toggle_bit_cnt", SCW'(bit_cnt), SCW'(1));

        // Counter saturation, then a load at saturation is rejected
        repeat (4100) step(1'b0, 1'b0, 1'b1);
        check("sat_bit_cnt", SCW'(bit_cnt), SCW'((1 << CW) - 1));
        do_load(1'b0, 1'b0);

        repeat (2) @(negedge ck_sr);
        check("exp_q_drained", SCW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/triroc_sc_chain_ctrl.md
TRIROC_SC_CHAIN_CTRL -- requirements
Module: triroc_sc_chain_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- SC_WIDTH, 1256, slow-control chain length in bits.
- PROBE_WIDTH, 416, probe chain length in bits.
- SC_RESET, all zeros (SC_WIDTH bits), slow-control reset pattern.
- PROBE_RESET, all zeros (PROBE_WIDTH bits), probe reset pattern.
- CNT_W, clog2(max(SC_WIDTH,PROBE_WIDTH)+1)+1, bit-counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- ck_sr, in, 1, shift clock, <10 MHz.
- rstb_sr, in, 1, reset; asynchronous, active-low.
- sr_in, in, 1, serial data in.
- select, in, 1, chain select: 1 = slow control, 0 = probe.
- load_sc, in, 1, active-low load request.
- sr_out, out, 1, serial data out.
- sc_cfg, out, SC_WIDTH, slow-control shadow (applied) configuration.
- probe_cfg, out, PROBE_WIDTH, probe shadow configuration.
- bit_cnt, out, CNT_W, number of bits shifted into the active chain.
- load_done, out, 1, one-cycle pulse on an accepted load.
- len_err, out, 1, the last load attempt had the wrong bit count.

Function
REQ-003 On each ck_sr posedge, only the selected chain SHALL shift: {chain[W-2:0], sr_in}. The unselected chain holds.
REQ-004 sr_out SHALL be a flop updated on the ck_sr negedge with the MSB of the currently selected chain.
REQ-005 bit_cnt SHALL increment by 1 on every posedge while not at the load edge, and SHALL saturate at 2^CNT_W-1.
REQ-006 select SHALL be registered into select_d on each posedge. On an edge where select != select_d, bit_cnt SHALL become 1, not increment.
REQ-007 load_sc SHALL be registered into load_sc_d on each posedge. A load event is load_sc==0 and load_sc_d==1 at a posedge.
REQ-008 Holding load_sc low for multiple cycles SHALL produce exactly one load event.
REQ-009 On a load event with select=1:
- If the pre-edge bit_cnt == SC_WIDTH, sc_cfg SHALL take the pre-edge SC chain value, load_done SHALL be 1 for the next cycle, and len_err SHALL become 0.
- Otherwise sc_cfg SHALL be unchanged, load_done SHALL stay 0, and len_err SHALL become 1.
REQ-010 On a load event with select=0, the same rules as REQ-009 SHALL apply, using PROBE_WIDTH and probe_cfg.
REQ-011 On a load event, bit_cnt SHALL become 0. This takes priority over REQ-005 and REQ-006.
REQ-012 On a load event, the chain shift at that edge SHALL still occur.
REQ-013 load_done SHALL be 0 on every posedge that is not a load event.
REQ-014 len_err SHALL be sticky and change only on load events or on reset.
REQ-015 A select change on the same edge as a load event SHALL use the new (sampled) select value for both the length check and the copy.
REQ-016 Shadow outputs SHALL change only on accepted loads or on reset, never during shifting.

Reset
REQ-017 While rstb_sr=0, the block SHALL hold these values regardless of ck_sr:
- SC chain and sc_cfg = SC_RESET.
- Probe chain and probe_cfg = PROBE_RESET.
- bit_cnt = 0, load_done = 0, len_err = 0.
- load_sc_d = 1, select_d = 1.
- sr_out = SC_RESET[SC_WIDTH-1].
REQ-018 Reset asserted mid-shift or mid-load SHALL discard partial data. Shadows SHALL return to their reset patterns.
REQ-019 After reset release, the first posedge SHALL behave per REQ-003 to REQ-016, with no spurious load event.

Structure
REQ-020 Package triroc_sc_pkg SHALL hold the SC_WIDTH and PROBE_WIDTH defaults, the CNT_W derivation function, and the chain-select encoding constants (SEL_SC=1, SEL_PROBE=0).
REQ-021 One sub-module, triroc_sr_chain, SHALL be used. It is parameterised by width and reset pattern, and contains the shift enable, the shadow copy enable, and the MSB output. It is instantiated once per chain.
REQ-022 The top level SHALL own the counter, edge detection, length check and negedge output flop.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then read outputs -> sc_cfg=SC_RESET, probe_cfg=PROBE_RESET, bit_cnt=0, load_done=0, len_err=0.
- select=1, shift 1256 random bits, pulse load_sc low -> sc_cfg equals the shifted pattern, load_done high for exactly one cycle, len_err=0, bit_cnt=0.
- select=1, shift 1255 bits, then load -> sc_cfg unchanged, load_done=0, len_err=1. A following correct 1256-bit load clears len_err.
- select=0, shift 416 bits, then load -> probe_cfg updated and the SC chain is bit-identical to before. sr_out changes only on negedges and lags the probe MSB by half a cycle.
- Assert rstb_sr after 600 bits, asynchronously mid-cycle -> all state is immediately reset and bit_cnt=0. A fresh 1256-bit load then succeeds.
- Hold load_sc low for 5 cycles -> a single load_done pulse. Toggle select after 10 bits -> bit_cnt=1.
